kernel_window_buffer: RTL and testbench

Parametrised K×K shift buffer that loads one convolution kernel (weights) or one input window through a valid/ready handshake and presents all K² words in parallel to the multiply-accumulate array. Successor to the fixed 5×5, 32-bit, 25-port shift FIFO in the convolution layers. It adds:
- an arbitrary kernel size and width,
- a single flattened output bus,
- a load state machine with fill count and a completion pulse,
- a rotate mode that recirculates the loaded contents without reloading.

---
 rtl/kernel_window_buffer_if.sv | 35 +++
 rtl/kernel_window_buffer.sv | 129 ++++++++++++
 tb/tb_kernel_window_buffer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_buffer_if
// Description : Load handshake between a word source and kernel_window_buffer.
//               master drives load_start / data_valid / data_in and observes
//               data_ready; slave is the buffer side.
// Ports       : load_start  - begin a new load (highest priority)
//               data_valid  - data_in carries a word
//               data_in     - word to shift in (DATA_WIDTH bits)
//               data_ready  - buffer accepts a word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface kernel_window_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  load_start;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_ready;

    modport master (
        output load_start,
        output data_valid,
        output data_in,
        input  data_ready
    );

    modport slave (
        input  load_start,
        input  data_valid,
        input  data_in,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/kernel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : kernel_window_buffer
// Description : K x K shift buffer. Loads one kernel or input window word by
//               word through a valid/ready handshake and presents all K*K
//               words in parallel on a single flattened bus. Once full, the
//               contents can be recirculated one word per cycle (rotate).
// Ports       : clk           - rising-edge clock
//               reset         - asynchronous, active-low reset
//               bus           - load handshake (slave side)
//               rotate_en     - rotate once per cycle while FULL
//               fill_count    - words accepted since the last load_start
//               window_full   - all FIFO_SIZE words loaded
//               load_done     - one-cycle pulse on entry to FULL
//               fifo_data_out - slot k (1..N) at [k*DATA_WIDTH-1:(k-1)*DATA_WIDTH],
//                               slot 1 oldest, slot N newest
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_window_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNAL_SIZE = 5,
    parameter int FIFO_SIZE   = KERNAL_SIZE * KERNAL_SIZE
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    kernel_window_buffer_if.slave                  bus,
    input  wire logic                              rotate_en,
    output logic [$clog2(FIFO_SIZE+1)-1:0]         fill_count,
    output logic                                   window_full,
    output logic                                   load_done,
    output logic [FIFO_SIZE*DATA_WIDTH-1:0]        fifo_data_out
);

    localparam int CNT_W = $clog2(FIFO_SIZE + 1);
    localparam logic [CNT_W-1:0] c_LAST_FILL = CNT_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_fill;
    logic                  r_load_done;
    // r_entries[0] is the newest word, r_entries[FIFO_SIZE-1] the oldest.
    logic [DATA_WIDTH-1:0] r_entries [FIFO_SIZE];

    logic w_accept;
    logic w_last;
    logic w_rotate;

    // load_start blocks both an accept and a rotation in the same cycle.
    assign w_accept = bus.data_valid && (r_state == S_LOAD) && !bus.load_start;
    assign w_last   = w_accept && (r_fill == c_LAST_FILL);
    assign w_rotate = rotate_en && (r_state == S_FULL) && !bus.load_start;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.load_start) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_LOAD:  w_state_next = w_last ? S_FULL : S_LOAD;
                S_FULL:  w_state_next = S_FULL;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill      <= '0;
            r_load_done <= 1'b0;
            for (int i = 0; i < FIFO_SIZE; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            // Registered so the pulse lines up with the first FULL cycle.
            r_load_done <= w_last;
            if (bus.load_start) begin
                r_fill <= '0;
                for (int i = 0; i < FIFO_SIZE; i++) begin
                    r_entries[i] <= '0;
                end
            end else if (w_accept) begin
                r_fill       <= r_fill + c_ONE;
                r_entries[0] <= bus.data_in;
                for (int i = 1; i < FIFO_SIZE; i++) begin
                    r_entries[i] <= r_entries[i-1];
                end
            end else if (w_rotate) begin
                // Oldest word wraps around to the newest position.
                r_entries[0] <= r_entries[FIFO_SIZE-1];
                for (int i = 1; i < FIFO_SIZE; i++) begin
                    r_entries[i] <= r_entries[i-1];
                end
            end
        end
    end

    // ----------------------------------------------------------- outputs
    assign bus.data_ready = (r_state == S_LOAD);
    assign window_full    = (r_state == S_FULL);
    assign fill_count     = r_fill;
    assign load_done      = r_load_done;

    // Slot k+1 (0-based k) is entry FIFO_SIZE-1-k: slot 1 oldest, slot N newest.
    generate
        for (genvar k = 0; k < FIFO_SIZE; k++) begin : g_slot
            assign fifo_data_out[k*DATA_WIDTH +: DATA_WIDTH] = r_entries[FIFO_SIZE-1-k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_window_buffer
// Description : Self-checking bench for kernel_window_buffer. A 5x5/32-bit
//               instance covers load, gapped load, rotation, reset and
//               restart; a 3x3/8-bit instance covers the parameter sweep.
//               Expected windows are queued when a load is driven and
//               compared when the buffer pulses load_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_window_buffer;

    localparam int DW  = 32;
    localparam int K   = 5;
    localparam int N   = K * K;
    localparam int SDW = 8;
    localparam int SK  = 3;
    localparam int SN  = SK * SK;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rot     = 1'b0;
    logic rot_s   = 1'b0;

    kernel_window_buffer_if #(.DATA_WIDTH(DW))  bus   ();
    kernel_window_buffer_if #(.DATA_WIDTH(SDW)) bus_s ();

    logic [$clog2(N+1)-1:0]  fill;
    logic                    full;
    logic                    done;
    logic [N*DW-1:0]         dout;
    logic [$clog2(SN+1)-1:0] fill_s;
    logic                    full_s;
    logic                    done_s;
    logic [SN*SDW-1:0]       dout_s;

    kernel_window_buffer #(.DATA_WIDTH(DW), .KERNAL_SIZE(K)) u_dut (
        .clk           (clk),
        .reset         (reset_n),
        .bus           (bus.slave),
        .rotate_en     (rot),
        .fill_count    (fill),
        .window_full   (full),
        .load_done     (done),
        .fifo_data_out (dout)
    );

    kernel_window_buffer #(.DATA_WIDTH(SDW), .KERNAL_SIZE(SK)) u_dut_small (
        .clk           (clk),
        .reset         (reset_n),
        .bus           (bus_s.slave),
        .rotate_en     (rot_s),
        .fill_count    (fill_s),
        .window_full   (full_s),
        .load_done     (done_s),
        .fifo_data_out (dout_s)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_cnt   = 0;
    int done_cnt_s = 0;
    logic [799:0] sb_q   [$];
    logic [799:0] sb_q_s [$];

    task automatic check(input string tag, input logic [799:0] obs, input logic [799:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected big window: slot k holds base+k-1.
    function automatic logic [799:0] big_win(input int base);
        logic [799:0] v;
        v = '0;
        for (int k = 1; k <= N; k++) v[(k-1)*DW +: DW] = DW'(base + k - 1);
        return v;
    endfunction

    // Expected small window: slot k holds 0xA0+k.
    function automatic logic [799:0] small_win();
        logic [799:0] v;
        v = '0;
        for (int k = 1; k <= SN; k++) v[(k-1)*SDW +: SDW] = SDW'(8'hA0 + k);
        return v;
    endfunction

    task automatic pulse_start();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic load_words(input int base, input int count);
        for (int i = 0; i < count; i++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = DW'(base + i);
            step();
        end
        bus.data_valid = 1'b0;
    endtask

    // Scoreboard: compare the parallel output whenever a load completes.
    always @(negedge clk) begin
        logic [799:0] e;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("big_unexpected_done", 800'd1, 800'd0);
            end else begin
                e = sb_q.pop_front();
                check("big_window", 800'(dout), e);
            end
        end
        if (done_s === 1'b1) begin
            done_cnt_s++;
            if (sb_q_s.size() == 0) begin
                check("small_unexpected_done", 800'd1, 800'd0);
            end else begin
                e = sb_q_s.pop_front();
                check("small_window", 800'(dout_s), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cycles;
        int accepts;
        int cyc;

        bus.load_start   = 1'b0;
        bus.data_valid   = 1'b0;
        bus.data_in      = '0;
        bus_s.load_start = 1'b0;
        bus_s.data_valid = 1'b0;
        bus_s.data_in    = '0;

        // ---- reset state
        repeat (3) step();
        check("rst_ready", 800'(bus.data_ready), 800'd0);
        check("rst_full",  800'(full), 800'd0);
        check("rst_fill",  800'(fill), 800'd0);
        check("rst_done",  800'(done), 800'd0);
        check("rst_dout",  800'(dout), 800'd0);

        // ---- IDLE ignores data
        reset_n        = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 32'd5;
        step();
        step();
        check("idle_ready", 800'(bus.data_ready), 800'd0);
        check("idle_fill",  800'(fill), 800'd0);
        check("idle_dout",  800'(dout), 800'd0);
        bus.data_valid = 1'b0;

        // ---- continuous load 1..25
        pulse_start();
        check("load_entry_fill",  800'(fill), 800'd0);
        check("load_entry_ready", 800'(bus.data_ready), 800'd1);
        sb_q.push_back(big_win(1));
        ready_cycles = 0;
        for (int i = 1; i <= N; i++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = DW'(i);
            if (bus.data_ready) ready_cycles++;
            step();
            check("fill_inc", 800'(fill), 800'(i));
        end
        bus.data_valid = 1'b0;
        check("full_after_last", 800'(full), 800'd1);
        check("done_high",       800'(done), 800'd1);
        check("ready_low",       800'(bus.data_ready), 800'd0);
        step();
        check("done_one_cycle",  800'(done), 800'd0);
        check("ready_cycles",    800'(ready_cycles), 800'(N));
        check("slot1",  800'(dout[0 +: DW]), 800'd1);
        check("slotN",  800'(dout[(N-1)*DW +: DW]), 800'd25);

        // ---- rotation, with data_valid asserted (must be ignored)
        rot            = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 32'd77;
        step();
        rot = 1'b0;
        check("rot1_slot1", 800'(dout[0 +: DW]), 800'd2);
        check("rot1_slotN", 800'(dout[(N-1)*DW +: DW]), 800'd1);
        check("rot1_fill",  800'(fill), 800'(N));
        rot = 1'b1;
        repeat (N - 1) step();
        rot            = 1'b0;
        bus.data_valid = 1'b0;
        check("rot_full_cycle", 800'(dout), big_win(1));
        check("rot_no_done",    800'(done_cnt), 800'd1);

        // ---- load_start beats rotate_en
        rot            = 1'b1;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        rot            = 1'b0;
        check("restart_dout",  800'(dout), 800'd0);
        check("restart_fill",  800'(fill), 800'd0);
        check("restart_full",  800'(full), 800'd0);
        check("restart_ready", 800'(bus.data_ready), 800'd1);

        // ---- gapped load: valid every other cycle
        sb_q.push_back(big_win(1));
        accepts = 0;
        cyc     = 0;
        while (accepts < N && cyc < 200) begin
            bus.data_valid = (cyc % 2 == 0);
            bus.data_in    = DW'(accepts + 1);
            if (bus.data_valid && bus.data_ready) accepts++;
            step();
            cyc++;
            check("gap_fill_max", 800'(fill <= N), 800'd1);
        end
        bus.data_valid = 1'b0;
        check("gap_accepts", 800'(accepts), 800'(N));
        check("gap_full",    800'(full), 800'd1);
        check("gap_fill",    800'(fill), 800'(N));
        step();
        check("gap_done_cnt", 800'(done_cnt), 800'd2);

        // ---- mid-load reset after 10 words
        pulse_start();
        load_words(1, 10);
        check("pre_rst_fill", 800'(fill), 800'd10);
        reset_n = 1'b0;
        #1;
        check("async_rst_dout",  800'(dout), 800'd0);
        check("async_rst_fill",  800'(fill), 800'd0);
        check("async_rst_ready", 800'(bus.data_ready), 800'd0);
        check("async_rst_full",  800'(full), 800'd0);
        check("async_rst_done",  800'(done), 800'd0);
        #2;
        reset_n = 1'b1;
        step();
        bus.data_valid = 1'b1;
        repeat (3) step();
        check("post_rst_ready", 800'(bus.data_ready), 800'd0);
        check("post_rst_fill",  800'(fill), 800'd0);
        bus.data_valid = 1'b0;

        // ---- load_start at word 12 together with data 99
        pulse_start();
        load_words(1, 11);
        bus.load_start = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 32'd99;
        step();
        bus.load_start = 1'b0;
        bus.data_valid = 1'b0;
        check("abort_fill",  800'(fill), 800'd0);
        check("abort_dout",  800'(dout), 800'd0);
        check("abort_ready", 800'(bus.data_ready), 800'd1);
        sb_q.push_back(big_win(101));
        load_words(101, N);
        check("reload_full", 800'(full), 800'd1);
        step();
        check("reload_done_cnt", 800'(done_cnt), 800'd3);

        // ---- 3x3, 8-bit instance
        bus_s.load_start = 1'b1;
        step();
        bus_s.load_start = 1'b0;
        sb_q_s.push_back(small_win());
        for (int i = 1; i <= SN; i++) begin
            bus_s.data_valid = 1'b1;
            bus_s.data_in    = SDW'(8'hA0 + i);
            step();
        end
        bus_s.data_valid = 1'b0;
        check("small_done", 800'(done_s), 800'd1);
        check("small_full", 800'(full_s), 800'd1);
        check("small_fill", 800'(fill_s), 800'(SN));
        step();
        check("small_slot1", 800'(dout_s[7:0]),   800'h0A1);
        check("small_slot9", 800'(dout_s[71:64]), 800'h0A9);
        check("small_done_cnt", 800'(done_cnt_s), 800'd1);

        check("sb_big_empty",   800'(sb_q.size()),   800'd0);
        check("sb_small_empty", 800'(sb_q_s.size()), 800'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
